rf_write_scheduler: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback and a multicycle long-latency unit (MDU/load unit) result path. The long-latency unit uses a valid/ready handshake.
- Keeps a per-register scoreboard of outstanding long-latency destinations and stalls the issue stage on RAW/WAW hazards, outstanding-limit overflow, or long-unit starvation.
- Sits between decode/issue, the long-latency unit and the register file. The register file writes on the falling clock edge and has asynchronous read.

---
 rtl/rf_write_scheduler_pkg.sv | 16 +
 rtl/rf_write_scheduler_if.sv | 15 +
 rtl/rf_write_scheduler_scoreboard.sv | 40 ++++
 rtl/rf_write_scheduler.sv | 113 +++++++++++
 tb/tb_rf_write_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// Shared defaults and width helpers for the register-file write scheduler.
package rf_sched_pkg;

  localparam int WIDTH_DEF           = 32;
  localparam int DEPTH_BITS_DEF      = 5;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int STARVE_LIMIT_DEF    = 8;

  // Counter width able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Valid/ready result channel from the long-latency unit into the write scheduler.
interface rf_write_scheduler_if
  import rf_sched_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
);
  logic                  valid;
  logic [DEPTH_BITS-1:0] rd;
  logic [WIDTH-1:0]      data;
  logic                  ready;

  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/rf_write_scheduler_scoreboard.sv
// Pending-destination scoreboard for long-latency ops with same-cycle bypass of retiring results.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_en,
  input  logic [DEPTH_BITS-1:0]        clr_addr,
  input  logic                         set_en,
  input  logic [DEPTH_BITS-1:0]        set_addr,
  input  logic [DEPTH_BITS-1:0]        rs1,
  input  logic [DEPTH_BITS-1:0]        rs2,
  input  logic [DEPTH_BITS-1:0]        rd,
  output logic                         raw,
  output logic                         waw,
  output logic [(1<<DEPTH_BITS)-1:0]   pending,
  output logic [(1<<DEPTH_BITS)-1:0]   clr_vec
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] eff;

  assign clr_vec = clr_en ? (DEPTH'(1) << clr_addr) : '0;
  assign set_vec = (set_en && (set_addr != '0)) ? (DEPTH'(1) << set_addr) : '0;

  // A result retiring this cycle reaches the register file before decode reads it.
  assign eff = pending & ~clr_vec;
  assign raw = eff[rs1] | eff[rs2];
  assign waw = eff[rd];

  // Set is OR-ed after the clear so a same-cycle reissue keeps the bit; x0 never pends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= ((pending & ~clr_vec) | set_vec) & ~DEPTH'(1);
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between pipeline writeback and the long-latency
// unit, and stalls issue on scoreboard hazards, in-flight limit or long-unit starvation.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int DEPTH_BITS      = DEPTH_BITS_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   iss_valid,
  input  logic [DEPTH_BITS-1:0]                  iss_rs1,
  input  logic [DEPTH_BITS-1:0]                  iss_rs2,
  input  logic [DEPTH_BITS-1:0]                  iss_rd,
  input  logic                                   iss_long,
  output logic                                   stall,
  input  logic                                   wb_en,
  input  logic [DEPTH_BITS-1:0]                  wb_addr,
  input  logic [WIDTH-1:0]                       wb_data,
  rf_write_scheduler_if.slave                    lu,
  output logic                                   WrEn,
  output logic [DEPTH_BITS-1:0]                  WrAddress,
  output logic [WIDTH-1:0]                       WrData,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]  outstanding,
  output logic                                   sb_err
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam int STV_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic             acc;
  logic             iss_go;
  logic             inc;
  logic             up_sat;
  logic             dn_sat;
  logic             lu_err;
  logic             wb_err;
  logic             raw;
  logic             waw;
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] clr_vec;
  logic [STV_W-1:0] starve_cnt;

  // Pipeline writeback always owns the port; the long unit only gets idle cycles.
  assign acc      = lu.valid && !wb_en;
  assign lu.ready = acc;

  assign stall = iss_valid && (raw || waw ||
                               (iss_long && (outstanding == CNT_MAX) && !acc) ||
                               (starve_cnt >= STV_MAX));
  assign iss_go = iss_valid && !stall;
  assign inc    = iss_go && iss_long;

  rf_scoreboard #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (acc),
    .clr_addr (lu.rd),
    .set_en   (inc),
    .set_addr (iss_rd),
    .rs1      (iss_rs1),
    .rs2      (iss_rs2),
    .rd       (iss_rd),
    .raw      (raw),
    .waw      (waw),
    .pending  (pending),
    .clr_vec  (clr_vec)
  );

  always_comb begin
    WrEn      = 1'b0;
    WrAddress = '0;
    WrData    = '0;
    if (wb_en) begin
      WrEn      = 1'b1;
      WrAddress = wb_addr;
      WrData    = wb_data;
    end else if (acc) begin
      WrEn      = (lu.rd != '0);
      WrAddress = lu.rd;
      WrData    = lu.data;
    end
  end

  assign up_sat = inc && !acc && (outstanding == CNT_MAX);
  assign dn_sat = acc && !inc && (outstanding == '0);
  assign lu_err = acc && (lu.rd != '0) && !pending[lu.rd];
  assign wb_err = wb_en && (wb_addr != '0) && pending[wb_addr] && !clr_vec[wb_addr];

  // Counters and sticky error; rd=0 long ops still occupy an in-flight slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      starve_cnt  <= '0;
      sb_err      <= 1'b0;
    end else begin
      if (inc && !acc && !up_sat)      outstanding <= outstanding + 1'b1;
      else if (acc && !inc && !dn_sat) outstanding <= outstanding - 1'b1;

      if (!lu.valid || acc)            starve_cnt <= '0;
      else if (starve_cnt != STV_MAX)  starve_cnt <= starve_cnt + 1'b1;

      if (lu_err || wb_err || up_sat || dn_sat) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed and randomized bench for rf_write_scheduler against an array-based reference model.
module tb_rf_write_scheduler;
  localparam int W    = 32;
  localparam int DB   = 5;
  localparam int D    = 1 << DB;
  localparam int MAXO = 4;
  localparam int SL   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic [DB-1:0] iss_rs1;
  logic [DB-1:0] iss_rs2;
  logic [DB-1:0] iss_rd;
  logic          iss_long;
  logic          stall;
  logic          wb_en;
  logic [DB-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          WrEn;
  logic [DB-1:0] WrAddress;
  logic [W-1:0]  WrData;
  logic [2:0]    outstanding;
  logic          sb_err;

  rf_write_scheduler_if #(.WIDTH(W), .DEPTH_BITS(DB)) lu_bus ();

  always #5 clk = ~clk;

  rf_write_scheduler #(
    .WIDTH(W), .DEPTH_BITS(DB), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_long(iss_long), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu(lu_bus),
    .WrEn(WrEn), .WrAddress(WrAddress), .WrData(WrData),
    .outstanding(outstanding), .sb_err(sb_err)
  );

  int ncmp = 0;
  int nbad = 0;

  // Reference model state
  bit m_pend [D];
  int m_out;
  int m_starve;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
    m_out = 0; m_starve = 0; m_err = 1'b0;
  endtask

  function automatic bit m_acc();
    return lu_bus.valid && !wb_en;
  endfunction

  function automatic bit m_eff(input int a);
    return (a != 0) && m_pend[a] && !(m_acc() && int'(lu_bus.rd) == a);
  endfunction

  function automatic bit m_stall();
    if (!iss_valid) return 1'b0;
    if (m_eff(int'(iss_rs1)) || m_eff(int'(iss_rs2)) || m_eff(int'(iss_rd))) return 1'b1;
    if (iss_long && m_out == MAXO && !m_acc()) return 1'b1;
    return m_starve >= SL;
  endfunction

  task automatic expect_now();
    bit          acc;
    bit          ee;
    logic [31:0] ea;
    logic [31:0] ed;
    acc = m_acc();
    ee = 1'b0; ea = '0; ed = '0;
    if (wb_en) begin
      ee = 1'b1; ea = 32'(wb_addr); ed = wb_data;
    end else if (acc) begin
      ee = (lu_bus.rd != '0); ea = 32'(lu_bus.rd); ed = lu_bus.data;
    end
    chk("stall",       32'(stall),        32'(m_stall()));
    chk("lu_ready",    32'(lu_bus.ready), 32'(acc));
    chk("WrEn",        32'(WrEn),         32'(ee));
    chk("WrAddress",   32'(WrAddress),    ea);
    chk("WrData",      WrData,            ed);
    chk("outstanding", 32'(outstanding),  32'(m_out));
    chk("sb_err",      32'(sb_err),       32'(m_err));
  endtask

  task automatic model_update();
    bit acc;
    bit go;
    bit inc;
    int lrd;
    acc = m_acc();
    go  = iss_valid && !m_stall();
    inc = go && iss_long;
    lrd = int'(lu_bus.rd);
    if (acc && lrd != 0 && !m_pend[lrd]) m_err = 1'b1;
    if (wb_en && wb_addr != 0 && m_pend[wb_addr] && !(acc && lrd == int'(wb_addr))) m_err = 1'b1;
    if (inc && !acc) begin
      if (m_out == MAXO) m_err = 1'b1; else m_out++;
    end else if (acc && !inc) begin
      if (m_out == 0) m_err = 1'b1; else m_out--;
    end
    if (acc) m_pend[lrd] = 1'b0;
    if (inc && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (!lu_bus.valid || acc) m_starve = 0;
    else if (m_starve < SL) m_starve++;
  endtask

  task automatic step();
    #2;
    expect_now();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input bit v, input bit lng, input int rs1, input int rs2, input int rd);
    iss_valid = v; iss_long = lng;
    iss_rs1 = DB'(rs1); iss_rs2 = DB'(rs2); iss_rd = DB'(rd);
  endtask

  task automatic lu_drive(input bit v, input int rd, input logic [31:0] data);
    lu_bus.valid = v; lu_bus.rd = DB'(rd); lu_bus.data = data;
  endtask

  task automatic wb_drive(input bit en, input int addr, input logic [31:0] data);
    wb_en = en; wb_addr = DB'(addr); wb_data = data;
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0);
    lu_drive(0, 0, '0);
    wb_drive(0, 0, '0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #1;
    chk("rst_stall",    32'(stall),        32'd0);
    chk("rst_lu_ready", 32'(lu_bus.ready), 32'd0);
    chk("rst_WrEn",     32'(WrEn),         32'd0);
    chk("rst_outst",    32'(outstanding),  32'd0);
    chk("rst_sb_err",   32'(sb_err),       32'd0);
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // Long op to x5, dependent reader stalls until the result retires
    issue(1, 1, 0, 0, 5); step();
    issue(1, 0, 5, 0, 6); #1;
    chk("raw_stall", 32'(stall), 32'd1);
    chk("raw_outst", 32'(outstanding), 32'd1);
    step();
    lu_drive(1, 5, 32'hDEADBEEF); #1;
    chk("acc_ready", 32'(lu_bus.ready), 32'd1);
    chk("acc_WrEn",  32'(WrEn), 32'd1);
    chk("acc_addr",  32'(WrAddress), 32'd5);
    chk("acc_data",  WrData, 32'hDEADBEEF);
    chk("acc_stall", 32'(stall), 32'd0);
    step();
    lu_drive(0, 0, '0); issue(1, 0, 5, 0, 0); #1;
    chk("clr_stall", 32'(stall), 32'd0);
    chk("clr_outst", 32'(outstanding), 32'd0);
    step();

    // Writeback priority and long-unit starvation
    issue(1, 1, 0, 0, 10); step();
    issue(1, 0, 0, 0, 0); wb_drive(1, 3, 32'h1234_5678); lu_drive(1, 10, 32'hCAFE_F00D); #1;
    chk("pri_ready", 32'(lu_bus.ready), 32'd0);
    chk("pri_addr",  32'(WrAddress), 32'd3);
    for (int i = 0; i < 8; i++) begin
      chk("starve_pre", 32'(stall), 32'd0);
      step();
    end
    #1;
    chk("starve_stall", 32'(stall), 32'd1);
    step();
    wb_drive(0, 0, '0); #1;
    chk("starve_acc", 32'(lu_bus.ready), 32'd1);
    step();
    lu_drive(0, 0, '0); #1;
    chk("starve_clr", 32'(stall), 32'd0);
    step();

    // Outstanding limit, relieved by a same-cycle accept
    for (int r = 1; r <= 4; r++) begin
      issue(1, 1, 0, 0, r); step();
    end
    #1;
    chk("full_outst", 32'(outstanding), 32'd4);
    issue(1, 1, 0, 0, 6); #1;
    chk("full_stall", 32'(stall), 32'd1);
    lu_drive(1, 1, 32'h0000_0001); #1;
    chk("full_relief", 32'(stall), 32'd0);
    step();
    #1;
    chk("full_keep", 32'(outstanding), 32'd4);
    issue(0, 0, 0, 0, 0);
    lu_drive(1, 2, 32'h2); step();
    lu_drive(1, 3, 32'h3); step();
    lu_drive(1, 4, 32'h4); step();
    lu_drive(1, 6, 32'h6); step();
    lu_drive(0, 0, '0); #1;
    chk("drain_outst", 32'(outstanding), 32'd0);

    // Long op targeting x0
    issue(1, 1, 0, 0, 0); step();
    issue(0, 0, 0, 0, 0); lu_drive(1, 0, 32'h5555_AAAA); #1;
    chk("x0_WrEn", 32'(WrEn), 32'd0);
    step();
    lu_drive(0, 0, '0); #1;
    chk("x0_outst", 32'(outstanding), 32'd0);
    chk("x0_err",   32'(sb_err), 32'd0);
    step();

    // Spurious result sets sticky error; async reset clears everything
    lu_drive(1, 7, 32'h7); step();
    lu_drive(0, 0, '0); step();
    #1;
    chk("err_sticky", 32'(sb_err), 32'd1);
    issue(1, 1, 0, 0, 12); step();
    idle();
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_outst", 32'(outstanding), 32'd0);
    chk("arst_err",   32'(sb_err), 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 12, 0, 0); #1;
    chk("arst_pend", 32'(stall), 32'd0);
    step();

    // Same-cycle retire and reissue of x9
    issue(1, 1, 0, 0, 9); step();
    lu_drive(1, 9, 32'h9999_0000); issue(1, 1, 0, 0, 9); #1;
    chk("reiss_stall", 32'(stall), 32'd0);
    step();
    lu_drive(0, 0, '0); issue(1, 0, 9, 0, 0); #1;
    chk("reiss_pend",  32'(stall), 32'd1);
    chk("reiss_outst", 32'(outstanding), 32'd1);
    step();
    issue(0, 0, 0, 0, 0); lu_drive(1, 9, 32'h9); step();
    idle(); step();

    // Randomized bursts, each starting from reset
    for (int b = 0; b < 10; b++) begin
      idle();
      #2 rst = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
        int s;
        int lrd;
        s = int'($urandom % 8);
        lrd = s;
        for (int k = 0; k < 8; k++) begin
          if (m_pend[(s + k) % 8]) begin
            lrd = (s + k) % 8;
            break;
          end
        end
        issue(($urandom % 4) != 0, $urandom % 2, int'($urandom % 8), int'($urandom % 8),
              int'($urandom % 8));
        wb_drive(($urandom % 3) == 0, int'($urandom % 8), $urandom);
        lu_drive(($urandom % 2) == 0, lrd, $urandom);
        step();
      end
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
